// File: rtl/ca3_theta_phase_memory_pkg.sv
// Shared constants, state codes and saturating weight arithmetic for the CA3
// theta-phase memory. Optional weight decay is enabled by CA3_WEIGHT_DECAY_EN.
package ca3_pkg;

   localparam int WIDTH        = 18;
   localparam int FRAC         = 14;
   localparam int N_UNITS      = 6;
   localparam int WEIGHT_W     = 8;
   localparam int THETA_HI     = 12288;
   localparam int THETA_LO     = -12288;
   localparam int W_INC        = 4;
   localparam int W_DEC        = 4;
   localparam int W_MAX        = 64;
   localparam int N_ITER       = 4;
   localparam int CUE_BOOST    = 32;
   localparam int DECAY_PERIOD = 1024;

   localparam int FIELD_W = WEIGHT_W + $clog2(N_UNITS) + 1;
   localparam int ROW_W   = $clog2(N_UNITS);
   localparam int ITER_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam int DCNT_W  = $clog2(DECAY_PERIOD);

   localparam logic signed [WIDTH-1:0]    THETA_HI_Q  = WIDTH'(THETA_HI);
   localparam logic signed [WIDTH-1:0]    THETA_LO_Q  = WIDTH'(THETA_LO);
   localparam logic signed [WEIGHT_W-1:0] W_MAX_Q     = WEIGHT_W'(W_MAX);
   localparam logic signed [WEIGHT_W-1:0] W_MIN_Q     = WEIGHT_W'(-W_MAX);
   localparam logic signed [WEIGHT_W-1:0] W_INC_Q     = WEIGHT_W'(W_INC);
   localparam logic signed [WEIGHT_W-1:0] W_DEC_NEG_Q = WEIGHT_W'(-W_DEC);

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_LEARN       = 4'd1,
      ST_LEARN_WAIT  = 4'd2,
      ST_RECALL_ITER = 4'd3,
      ST_RECALL_HOLD = 4'd4
   } state_e;

   // Add a signed step to a weight, clamping to [-W_MAX, +W_MAX].
   function automatic logic signed [WEIGHT_W-1:0] sat_add(
      input logic signed [WEIGHT_W-1:0] w,
      input logic signed [WEIGHT_W-1:0] d
   );
      logic signed [WEIGHT_W:0]   sum_s;
      logic signed [WEIGHT_W:0]   max_s;
      logic signed [WEIGHT_W-1:0] res_s;
      max_s = (WEIGHT_W+1)'(W_MAX);
      sum_s = $signed({w[WEIGHT_W-1], w}) + $signed({d[WEIGHT_W-1], d});
      if (sum_s > max_s) begin
         res_s = W_MAX_Q;
      end else if (sum_s < -max_s) begin
         res_s = W_MIN_Q;
      end else begin
         res_s = sum_s[WEIGHT_W-1:0];
      end
      return res_s;
   endfunction

   function automatic logic signed [WEIGHT_W-1:0] decay_step(
      input logic signed [WEIGHT_W-1:0] w
   );
      logic signed [WEIGHT_W-1:0] res_s;
      if (w > WEIGHT_W'(0)) begin
         res_s = w - WEIGHT_W'(1);
      end else if (w < WEIGHT_W'(0)) begin
         res_s = w + WEIGHT_W'(1);
      end else begin
         res_s = w;
      end
      return res_s;
   endfunction

endpackage

// File: rtl/ca3_theta_phase_memory_if.sv
// Bus bundle between the theta source / pattern driver and the CA3 memory.
interface ca3_theta_phase_memory_if;
   import ca3_pkg::*;

   logic                     clk_en;
   logic signed [WIDTH-1:0]  theta_x;
   logic [N_UNITS-1:0]       pattern_in;
   logic [N_UNITS-1:0]       phase_pattern;
   logic                     learning;
   logic                     recalling;
   logic [3:0]               debug_state;

   modport master (
      output clk_en, theta_x, pattern_in,
      input  phase_pattern, learning, recalling, debug_state
   );

   modport slave (
      input  clk_en, theta_x, pattern_in,
      output phase_pattern, learning, recalling, debug_state
   );

endinterface

// File: rtl/ca3_theta_phase_memory_field_unit.sv
// One CA3 unit: signed weighted sum of active inputs plus cue bias, thresholded at > 0.
module ca3_field_unit
   import ca3_pkg::*;
(
   input  logic [N_UNITS*WEIGHT_W-1:0] w_row,
   input  logic [N_UNITS-1:0]          s,
   input  logic                        cue_bit,
   output logic                        s_next
);

   logic signed [FIELD_W-1:0] h_s;

   // Field accumulation and sign decision.
   always_comb begin
      if (cue_bit) begin
         h_s = FIELD_W'(CUE_BOOST);
      end else begin
         h_s = '0;
      end
      for (int j = 0; j < N_UNITS; j++) begin
         if (s[j]) begin
            h_s = h_s + FIELD_W'($signed(w_row[j*WEIGHT_W +: WEIGHT_W]));
         end else begin
            h_s = h_s;
         end
      end
      s_next = !h_s[FIELD_W-1] && (h_s != '0);
   end

endmodule

// File: rtl/ca3_theta_phase_memory.sv
// Theta-gated Hebbian auto-associative memory: learns near theta peaks, recalls
// by attractor settling near troughs. Optional weight decay: CA3_WEIGHT_DECAY_EN.
module ca3_theta_phase_memory
   import ca3_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   ca3_theta_phase_memory_if.slave bus
);

   state_e                     state_r;
   logic [3:0]                 debug_state_r;
   logic [N_UNITS-1:0]         pat_r;
   logic [N_UNITS-1:0]         cue_r;
   logic [N_UNITS-1:0]         s_r;
   logic [N_UNITS-1:0]         phase_r;
   logic                       learning_r;
   logic                       recalling_r;
   logic [ROW_W-1:0]           row_r;
   logic [ITER_W-1:0]          iter_r;
   logic signed [WEIGHT_W-1:0] w_r [N_UNITS][N_UNITS];
`ifdef CA3_WEIGHT_DECAY_EN
   logic [DCNT_W-1:0]          decay_cnt_r;
`endif

   logic [N_UNITS*WEIGHT_W-1:0] w_row_s [N_UNITS];
   logic [N_UNITS-1:0]          s_next_s;
   logic                        pat_nz_s;
   logic                        theta_hi_s;
   logic                        theta_lo_s;

   // Gate conditions and flattened weight rows for the field units.
   always_comb begin
      pat_nz_s   = (bus.pattern_in != '0);
      theta_hi_s = (bus.theta_x >= THETA_HI_Q);
      theta_lo_s = (bus.theta_x <= THETA_LO_Q);
      for (int i = 0; i < N_UNITS; i++) begin
         w_row_s[i] = '0;
         for (int j = 0; j < N_UNITS; j++) begin
            w_row_s[i][j*WEIGHT_W +: WEIGHT_W] = w_r[i][j];
         end
      end
   end

   for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_field
      ca3_field_unit u_field (
         .w_row   (w_row_s[gi]),
         .s       (s_r),
         .cue_bit (cue_r[gi]),
         .s_next  (s_next_s[gi])
      );
   end

   // Control FSM, weight store and optional decay timer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         debug_state_r <= 4'd0;
         pat_r         <= '0;
         cue_r         <= '0;
         s_r           <= '0;
         phase_r       <= '0;
         learning_r    <= 1'b0;
         recalling_r   <= 1'b0;
         row_r         <= '0;
         iter_r        <= '0;
         for (int i = 0; i < N_UNITS; i++) begin
            for (int j = 0; j < N_UNITS; j++) begin
               w_r[i][j] <= '0;
            end
         end
`ifdef CA3_WEIGHT_DECAY_EN
         decay_cnt_r   <= '0;
`endif
      end else if (bus.clk_en) begin
`ifdef CA3_WEIGHT_DECAY_EN
         // A decay tick landing outside IDLE is dropped, not carried over.
         if (decay_cnt_r == DCNT_W'(DECAY_PERIOD-1)) begin
            decay_cnt_r <= '0;
            if (state_r == ST_IDLE) begin
               for (int i = 0; i < N_UNITS; i++) begin
                  for (int j = 0; j < N_UNITS; j++) begin
                     w_r[i][j] <= decay_step(w_r[i][j]);
                  end
               end
            end
         end else begin
            decay_cnt_r <= decay_cnt_r + DCNT_W'(1);
         end
`endif
         case (state_r)
            ST_IDLE: begin
               if (theta_hi_s && pat_nz_s) begin
                  state_r       <= ST_LEARN;
                  debug_state_r <= ST_LEARN;
                  learning_r    <= 1'b1;
                  pat_r         <= bus.pattern_in;
                  row_r         <= '0;
               end else if (theta_lo_s && pat_nz_s) begin
                  state_r       <= ST_RECALL_ITER;
                  debug_state_r <= ST_RECALL_ITER;
                  recalling_r   <= 1'b1;
                  cue_r         <= bus.pattern_in;
                  s_r           <= bus.pattern_in;
                  iter_r        <= '0;
               end
            end
            ST_LEARN: begin
               for (int j = 0; j < N_UNITS; j++) begin
                  if (j != int'(row_r)) begin
                     if (pat_r[row_r] && pat_r[j]) begin
                        w_r[row_r][j] <= sat_add(w_r[row_r][j], W_INC_Q);
                     end else if (pat_r[row_r] ^ pat_r[j]) begin
                        w_r[row_r][j] <= sat_add(w_r[row_r][j], W_DEC_NEG_Q);
                     end
                  end
               end
               if (row_r == ROW_W'(N_UNITS-1)) begin
                  state_r       <= ST_LEARN_WAIT;
                  debug_state_r <= ST_LEARN_WAIT;
                  learning_r    <= 1'b0;
               end else begin
                  row_r <= row_r + ROW_W'(1);
               end
            end
            ST_LEARN_WAIT: begin
               // Holding here until theta falls guarantees one learn per peak.
               if (!theta_hi_s) begin
                  state_r       <= ST_IDLE;
                  debug_state_r <= ST_IDLE;
               end
            end
            ST_RECALL_ITER: begin
               s_r     <= s_next_s;
               phase_r <= s_next_s;
               if (iter_r == ITER_W'(N_ITER-1)) begin
                  state_r       <= ST_RECALL_HOLD;
                  debug_state_r <= ST_RECALL_HOLD;
               end else begin
                  iter_r <= iter_r + ITER_W'(1);
               end
            end
            ST_RECALL_HOLD: begin
               if (!theta_lo_s || !pat_nz_s) begin
                  state_r       <= ST_IDLE;
                  debug_state_r <= ST_IDLE;
                  recalling_r   <= 1'b0;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               debug_state_r <= ST_IDLE;
               learning_r    <= 1'b0;
               recalling_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.phase_pattern = phase_r;
   assign bus.learning      = learning_r;
   assign bus.recalling     = recalling_r;
   assign bus.debug_state   = debug_state_r;

endmodule

// File: tb/tb_ca3_theta_phase_memory.sv
// Self-checking bench for ca3_theta_phase_memory: vector table, directed corner
// sequences and randomized learn/recall against a whole-pattern reference model.
module tb_ca3_theta_phase_memory;
   import ca3_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   ca3_theta_phase_memory_if bus_if ();

   ca3_theta_phase_memory dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int mw [N_UNITS][N_UNITS];

   typedef struct {
      int                 theta;
      logic [N_UNITS-1:0] pat;
      logic               exp_learn;
      logic               exp_rec;
      logic [3:0]         exp_state;
      logic [N_UNITS-1:0] exp_phase;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clk_en update; idle cycles in between carry junk inputs that must be ignored.
   task automatic upd(input int th, input logic [N_UNITS-1:0] p);
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
         bus_if.clk_en     = 1'b0;
         bus_if.theta_x    = WIDTH'($urandom);
         bus_if.pattern_in = N_UNITS'($urandom);
         @(posedge clk);
         #1;
      end
      bus_if.clk_en     = 1'b1;
      bus_if.theta_x    = WIDTH'(th);
      bus_if.pattern_in = p;
      @(posedge clk);
      #1;
      bus_if.clk_en = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N_UNITS; i++)
         for (int j = 0; j < N_UNITS; j++)
            mw[i][j] = 0;
   endtask

   task automatic model_learn(input logic [N_UNITS-1:0] p);
      for (int i = 0; i < N_UNITS; i++) begin
         for (int j = 0; j < N_UNITS; j++) begin
            if (i != j) begin
               if (p[i] && p[j]) mw[i][j] += W_INC;
               else if (p[i] != p[j]) mw[i][j] -= W_DEC;
               if (mw[i][j] > W_MAX) mw[i][j] = W_MAX;
               if (mw[i][j] < -W_MAX) mw[i][j] = -W_MAX;
            end
         end
      end
   endtask

   function automatic logic [N_UNITS-1:0] model_recall(input logic [N_UNITS-1:0] cue);
      logic [N_UNITS-1:0] s;
      logic [N_UNITS-1:0] ns;
      int h;
      s = cue;
      for (int it = 0; it < N_ITER; it++) begin
         for (int i = 0; i < N_UNITS; i++) begin
            h = cue[i] ? CUE_BOOST : 0;
            for (int j = 0; j < N_UNITS; j++)
               if (s[j]) h += mw[i][j];
            ns[i] = (h > 0);
         end
         s = ns;
      end
      return s;
   endfunction

   task automatic check_weights(input string tag);
      for (int i = 0; i < N_UNITS; i++)
         for (int j = 0; j < N_UNITS; j++)
            chk($sformatf("%s_w%0d%0d", tag, i, j), int'(dut.w_r[i][j]), mw[i][j]);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_phase"}, int'(bus_if.phase_pattern), 0);
      chk({tag, "_learning"}, int'(bus_if.learning), 0);
      chk({tag, "_recalling"}, int'(bus_if.recalling), 0);
      chk({tag, "_state"}, int'(bus_if.debug_state), 0);
   endtask

   task automatic do_reset();
      bus_if.clk_en = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_clear();
   endtask

   task automatic learn_event(input logic [N_UNITS-1:0] p);
      for (int k = 0; k < N_UNITS + 1; k++) upd(12300, p);
      chk("learn_wait_state", int'(bus_if.debug_state), 2);
      upd(0, p);
      chk("learn_back_idle", int'(bus_if.debug_state), 0);
      model_learn(p);
   endtask

   task automatic recall_event(input string tag, input logic [N_UNITS-1:0] cue,
                               input logic [N_UNITS-1:0] exp);
      for (int k = 0; k < N_ITER + 1; k++) upd(-12300, cue);
      chk({tag, "_phase"}, int'(bus_if.phase_pattern), int'(exp));
      chk({tag, "_recalling"}, int'(bus_if.recalling), 1);
      upd(0, cue);
      chk({tag, "_exit_recalling"}, int'(bus_if.recalling), 0);
      chk({tag, "_phase_retained"}, int'(bus_if.phase_pattern), int'(exp));
   endtask

   initial begin
      logic [N_UNITS-1:0] p;
      logic [N_UNITS-1:0] cue;
      int exp53;

      // learn 101010, settle to IDLE, then recall from cue 100000 and hold
      tbl[0] = '{12300, 6'b101010, 1'b1, 1'b0, 4'd1, 6'b000000};
      for (int k = 1; k < 6; k++) tbl[k] = '{12300, 6'b101010, 1'b1, 1'b0, 4'd1, 6'b000000};
      tbl[6] = '{12300, 6'b101010, 1'b0, 1'b0, 4'd2, 6'b000000};
      tbl[7] = '{0, 6'b101010, 1'b0, 1'b0, 4'd0, 6'b000000};
      tbl[8] = '{-12300, 6'b100000, 1'b0, 1'b1, 4'd3, 6'b000000};
      for (int k = 9; k < 12; k++) tbl[k] = '{-12300, 6'b100000, 1'b0, 1'b1, 4'd3, 6'b101010};
      for (int k = 12; k < 19; k++) tbl[k] = '{-12300, 6'b100000, 1'b0, 1'b1, 4'd4, 6'b101010};
      tbl[19] = '{0, 6'b100000, 1'b0, 1'b0, 4'd0, 6'b101010};

      bus_if.clk_en     = 1'b0;
      bus_if.theta_x    = '0;
      bus_if.pattern_in = '0;
      model_clear();
      #12;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int k = 0; k < 20; k++) begin
         upd(tbl[k].theta, tbl[k].pat);
         chk($sformatf("tbl%0d_learning", k), int'(bus_if.learning), int'(tbl[k].exp_learn));
         chk($sformatf("tbl%0d_recalling", k), int'(bus_if.recalling), int'(tbl[k].exp_rec));
         chk($sformatf("tbl%0d_state", k), int'(bus_if.debug_state), int'(tbl[k].exp_state));
         chk($sformatf("tbl%0d_phase", k), int'(bus_if.phase_pattern), int'(tbl[k].exp_phase));
         if (k == 7) begin
            model_learn(6'b101010);
            check_weights("learn1");
            chk("w53_pos", int'(dut.w_r[5][3]), 4);
            chk("w54_neg", int'(dut.w_r[5][4]), -4);
            chk("w50_neg", int'(dut.w_r[5][0]), -4);
         end
      end

      // asynchronous reset in the middle of a recall
      upd(-12300, 6'b100000);
      upd(-12300, 6'b100000);
      chk("pre_reset_recalling", int'(bus_if.recalling), 1);
      #2;
      rst = 1'b0;
      #1;
      check_idle_outputs("midrecall_reset");
      model_clear();
      check_weights("midrecall_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // two complementary patterns
      do_reset();
      for (int k = 0; k < 5; k++) learn_event(6'b101010);
      for (int k = 0; k < 5; k++) learn_event(6'b010101);
      check_weights("two_pat");
      recall_event("cueA", 6'b100000, 6'b101010);
      recall_event("cueB", 6'b000100, 6'b010101);
      chk("model_cueA", int'(model_recall(6'b100000)), int'(6'b101010));

      // saturation
      do_reset();
      for (int k = 0; k < 20; k++) learn_event(6'b111111);
      check_weights("sat");
      chk("sat_w50", int'(dut.w_r[5][0]), 64);
      chk("sat_w11", int'(dut.w_r[1][1]), 0);

      // randomized learn/recall against the model
      do_reset();
      for (int r = 0; r < 6; r++) begin
         p = N_UNITS'($urandom_range(1, 63));
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) learn_event(p);
         cue = N_UNITS'($urandom_range(1, 63));
         recall_event($sformatf("rnd%0d", r), cue, model_recall(cue));
      end
      check_weights("rnd");

      // decay over long idle stretch
      do_reset();
      learn_event(6'b101010);
      bus_if.theta_x    = '0;
      bus_if.pattern_in = '0;
      bus_if.clk_en     = 1'b1;
      repeat (4 * DECAY_PERIOD) @(posedge clk);
      #1;
      bus_if.clk_en = 1'b0;
`ifdef CA3_WEIGHT_DECAY_EN
      exp53 = 0;
`else
      exp53 = 4;
`endif
      chk("decay_w53", int'(dut.w_r[5][3]), exp53);
      chk("decay_state", int'(bus_if.debug_state), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ca3_theta_phase_memory.md
Name: ca3_theta_phase_memory

Overview:
- Theta-gated Hebbian auto-associative memory with N_UNITS binary units, modelling hippocampal CA3.
- Encodes (learns) the presented pattern near theta peaks.
- Near theta troughs, retrieves (recalls) a stored pattern from a partial cue by iterative attractor settling.
- Sits downstream of the theta Hopf oscillator (thalamic rhythm) and runs at the clk_en update rate (4 kHz nominal).

Parameters:
- WIDTH, 18, signed fixed-point width of theta_x.
- FRAC, 14, fractional bits of theta_x (1.0 = 16384).
- N_UNITS, 6, number of memory units (pattern width).
- WEIGHT_W, 8, signed weight width.
- THETA_HI, 12288, learn-gate threshold (0.75).
- THETA_LO, -12288, recall-gate threshold (-0.75).
- W_INC, 4, potentiation step.
- W_DEC, 4, depression step.
- W_MAX, 64, weight saturation magnitude (weights clamp to [-W_MAX, +W_MAX]).
- N_ITER, 4, recall iterations.
- CUE_BOOST, 32, external-cue field bias.
- DECAY_PERIOD, 1024, clk_en updates between decay steps.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- clk_en  in  1  update strobe; all state advances only when clk_en=1.
- theta_x  in  WIDTH  signed theta oscillator output.
- pattern_in  in  N_UNITS  pattern to learn, or recall cue.
- phase_pattern  out  N_UNITS  recalled pattern.
- learning  out  1  high while in LEARN.
- recalling  out  1  high while in RECALL_ITER or RECALL_HOLD.
- debug_state  out  4  current state code.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all weights 0; phase_pattern=0; learning=0; recalling=0; decay counter=0; debug_state=0.
  - Reset mid-operation aborts immediately.
- State codes: IDLE=0, LEARN=1, LEARN_WAIT=2, RECALL_ITER=3, RECALL_HOLD=4.
- Every transition below is evaluated on a clk_en cycle; all outputs are registered.
- IDLE:
  - theta_x >= THETA_HI and pattern_in != 0 → LEARN (learning=1 from this edge).
  - Else if theta_x <= THETA_LO and pattern_in != 0 → RECALL_ITER; latch cue=pattern_in; state vector s=cue; recalling=1.
  - Learn check takes priority (the two conditions cannot both hold).
- LEARN:
  - Processes one row i per update over N_UNITS updates.
  - For each j != i: p[i]&p[j] → w[i][j] += W_INC; p[i]^p[j] → w[i][j] -= W_DEC; both-zero → unchanged. Result is saturated.
  - p is pattern_in latched on LEARN entry. Diagonal stays 0.
  - After the last row → LEARN_WAIT; learning=0.
- LEARN_WAIT: stays until theta_x < THETA_HI, then → IDLE. Exactly one learning event per theta peak.
- RECALL_ITER:
  - One synchronous iteration per update: h_i = Σ_j w[i][j]·s_j + (cue_i ? CUE_BOOST : 0); s_i' = (h_i > 0).
  - The field sum uses signed arithmetic wide enough for no overflow (WEIGHT_W + clog2(N_UNITS) + 1).
  - phase_pattern <= s' each iteration.
  - After N_ITER iterations → RECALL_HOLD.
- RECALL_HOLD:
  - recalling stays 1 and phase_pattern holds.
  - theta_x > THETA_LO or pattern_in == 0 → IDLE; recalling=0.
  - phase_pattern retains its last value in IDLE.
- clk_en=0: everything holds.
- Weights of the two complementary stored patterns coexist; cross-group weights go negative.

Optional Feature:
- Macro CA3_WEIGHT_DECAY_EN.
- Defined:
  - The decay counter increments on each clk_en update.
  - On reaching DECAY_PERIOD-1 it wraps to 0.
  - If state==IDLE on that update, every nonzero weight moves 1 toward 0.
  - A decay step due outside IDLE is skipped, not deferred.
- Undefined: no counter; weights persist until reset.

Decomposition:
- Shared package ca3_pkg:
  - state enum/codes;
  - default thresholds THETA_HI/THETA_LO;
  - weight width and saturation constants;
  - the saturating-add function.
- One sub-module: ca3_field_unit, a combinational per-unit weighted sum plus cue bias and sign. Instantiate it N_UNITS times.

Test Plan:
- Reset with rst=0 mid-RECALL → phase_pattern=0, learning=0, recalling=0, debug_state=0, all weights 0.
- pattern_in=101010, theta_x stepped to 12300 → learning=1 on the next clk_en; learning=0 after 6 updates; w[5][3]=+4, w[5][4]=-4, w[5][0]=-4.
- Learn 101010 once, theta_x=-12300, cue=100000 → recalling=1 within 1 update, still 1 after 10 updates; phase_pattern=101010 by update 5.
- Learn 101010 ×5 then 010101 ×5 at successive peaks → cue 100000 recalls 101010; cue 000100 recalls 010101 (6/6 bits).
- Saturation: 20 learns of 111111 → all off-diagonal weights =64 (no wrap).
- With CA3_WEIGHT_DECAY_EN: a single learn then 4×DECAY_PERIOD idle updates → w[5][3] = 0; without the macro → w[5][3] stays 4.
